// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Turns the raw byte stream coming out of uart_rx into flash commands for
//   the SPI flash engine. It waits for a SYNC byte, gathers the header
//   (opcode, 24-bit address MSB first, length, checksum), validates it, and
//   offers one command on a valid/ready handshake. For WRITE commands the
//   following payload bytes are forwarded through a one-entry hold register.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   rx_data, rx_strobe    received byte and its ready strobe (rising edge only)
//   cmd_valid, cmd_ready  command handshake
//   cmd_op/addr/len       command fields; cmd_len is 1..256
//   wr_data, wr_valid,    WRITE payload byte handshake
//   wr_ready
//   busy                  high whenever a frame is in progress
//   err, err_code         one-cycle error pulse and sticky cause
//                         (0 checksum, 1 opcode, 2 timeout, 3 overrun)
module uart_cmd_sequencer #(
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 400000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_strobe,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [23:0] cmd_addr,
    output logic [8:0]  cmd_len,
    output logic [7:0]  wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    OP_WRITE = 8'h03;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_LEN, S_CSUM, S_ISSUE, S_PAYLOAD
    } state_t;

    state_t        state, state_nxt;
    logic          strobe_q, evt;
    logic [7:0]    evt_data;
    logic [7:0]    hdr_op, hdr_a2, hdr_a1, hdr_a0, hdr_len;
    logic [TW-1:0] tcnt;
    logic          hold_full;
    logic [7:0]    hold_data;
    logic [8:0]    rcv_left, con_left;
    logic          err_set;
    logic [1:0]    err_code_nxt;

    logic       hdr_ok_sum, op_ok, is_write, wr_take, last_take;
    logic       payload_open, accept, overrun, timeout_hit;

    assign hdr_ok_sum   = (evt_data == (hdr_op ^ hdr_a2 ^ hdr_a1 ^ hdr_a0 ^ hdr_len));
    assign op_ok        = (hdr_op >= 8'h01) && (hdr_op <= 8'h05);
    assign is_write     = (cmd_op == OP_WRITE);
    assign wr_take      = wr_valid && wr_ready;
    assign last_take    = wr_take && (con_left == 9'd1);
    // Payload bytes are taken while the WRITE command is still being offered,
    // but only until the announced count has been received.
    assign payload_open = is_write && (rcv_left != 9'd0) &&
                          ((state == S_ISSUE) || (state == S_PAYLOAD));
    // A byte that lands in the same clock the hold register drains is fine.
    assign accept       = evt && payload_open && (!hold_full || wr_take);
    assign overrun      = evt && payload_open && hold_full && !wr_take;
    assign timeout_hit  = !evt && (tcnt == T_LAST) &&
                          (state != S_IDLE) && (state != S_ISSUE);

    assign cmd_valid = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);
    assign wr_valid  = hold_full && (state == S_PAYLOAD);
    assign wr_data   = hold_data;

    // Byte event: one-clock pulse from the registered rising edge of the
    // UART strobe, with the byte captured alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
            evt      <= 1'b0;
            evt_data <= 8'h00;
        end else begin
            strobe_q <= rx_strobe;
            evt      <= rx_strobe && !strobe_q;
            evt_data <= rx_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and error decision. Checksum is judged before the opcode,
    // and a timeout overrides anything else happening in that clock.
    always_comb begin
        state_nxt    = state;
        err_set      = 1'b0;
        err_code_nxt = err_code;
        case (state)
            S_IDLE:  if (evt && (evt_data == SYNC)) state_nxt = S_CMD;
            S_CMD:   if (evt) state_nxt = S_A2;
            S_A2:    if (evt) state_nxt = S_A1;
            S_A1:    if (evt) state_nxt = S_A0;
            S_A0:    if (evt) state_nxt = S_LEN;
            S_LEN:   if (evt) state_nxt = S_CSUM;
            S_CSUM: begin
                if (evt) begin
                    if (!hdr_ok_sum) begin
                        state_nxt    = S_IDLE;
                        err_set      = 1'b1;
                        err_code_nxt = 2'd0;
                    end else if (!op_ok) begin
                        state_nxt    = S_IDLE;
                        err_set      = 1'b1;
                        err_code_nxt = 2'd1;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (overrun) begin
                    state_nxt    = S_IDLE;
                    err_set      = 1'b1;
                    err_code_nxt = 2'd3;
                end else if (cmd_ready) begin
                    state_nxt = is_write ? S_PAYLOAD : S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (overrun) begin
                    state_nxt    = S_IDLE;
                    err_set      = 1'b1;
                    err_code_nxt = 2'd3;
                end else if (last_take) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_nxt    = S_IDLE;
            err_set      = 1'b1;
            err_code_nxt = 2'd2;
        end
    end

    // Header capture, command latch, payload hold register, counters and
    // error outputs. Anything returning to idle empties the hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_op    <= 8'h00;
            hdr_a2    <= 8'h00;
            hdr_a1    <= 8'h00;
            hdr_a0    <= 8'h00;
            hdr_len   <= 8'h00;
            cmd_op    <= 8'h00;
            cmd_addr  <= 24'h0;
            cmd_len   <= 9'd0;
            rcv_left  <= 9'd0;
            con_left  <= 9'd0;
            tcnt      <= '0;
            hold_full <= 1'b0;
            hold_data <= 8'h00;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            if (evt) begin
                case (state)
                    S_CMD:   hdr_op  <= evt_data;
                    S_A2:    hdr_a2  <= evt_data;
                    S_A1:    hdr_a1  <= evt_data;
                    S_A0:    hdr_a0  <= evt_data;
                    S_LEN:   hdr_len <= evt_data;
                    default: ;
                endcase
            end

            if ((state == S_CSUM) && (state_nxt == S_ISSUE)) begin
                cmd_op   <= hdr_op;
                cmd_addr <= {hdr_a2, hdr_a1, hdr_a0};
                cmd_len  <= {(hdr_len == 8'h00), hdr_len};
                rcv_left <= {(hdr_len == 8'h00), hdr_len};
                con_left <= {(hdr_len == 8'h00), hdr_len};
            end else begin
                if (accept)  rcv_left <= rcv_left - 9'd1;
                if (wr_take) con_left <= con_left - 9'd1;
            end

            if (evt || (state == S_IDLE) || (state == S_ISSUE)) tcnt <= '0;
            else                                                 tcnt <= tcnt + 1'b1;

            if (state_nxt == S_IDLE) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold_data <= evt_data;
            end else if (wr_take) begin
                hold_full <= 1'b0;
            end

            err      <= err_set;
            err_code <= err_code_nxt;
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer
//   Drives framed byte streams into uart_cmd_sequencer and compares the
//   command, payload and error outputs against expectations derived from the
//   frame contents. A short TIMEOUT is used so silence cases stay quick.
module tb_uart_cmd_sequencer;

    localparam int         TIMEOUT = 200;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_strobe = 1'b0;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready;
    logic        busy, err;
    logic [1:0]  err_code;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        logic [8:0]  len;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [7:0] exp_wr[$];
    logic [1:0] exp_err[$];

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int zc = 0;
    int zw = 0;
    bit monitor_on = 1'b0;

    uart_cmd_sequencer #(.SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_strobe(rx_strobe),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Hard stop so the run can never hang.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_unexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got 1 with nothing expected, expected 0", name);
    endtask

    // Ready generator: 0 both low, 1 both high, 2 random with never more than
    // two idle cycles in a row, 3 command accepted but payload stalled.
    initial begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: begin cmd_ready = 1'b0; wr_ready = 1'b0; end
                1: begin cmd_ready = 1'b1; wr_ready = 1'b1; end
                2: begin
                    cmd_ready = (zc >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
                    wr_ready  = (zw >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
                    zc = cmd_ready ? 0 : zc + 1;
                    zw = wr_ready  ? 0 : zw + 1;
                end
                default: begin cmd_ready = 1'b1; wr_ready = 1'b0; end
            endcase
        end
    end

    // Compare process: every offered command must match the oldest expected
    // one for as long as it is offered, every offered payload byte must match
    // the oldest expected byte, and every error pulse must carry the expected
    // cause while the block already reports idle.
    always @(negedge clk) begin
        if (rst_n && monitor_on) begin
            if (cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    report_unexpected("cmd_valid");
                end else begin
                    checkOutput("cmd_op",   32'(cmd_op),   32'(exp_cmd[0].op));
                    checkOutput("cmd_addr", 32'(cmd_addr), 32'(exp_cmd[0].addr));
                    checkOutput("cmd_len",  32'(cmd_len),  32'(exp_cmd[0].len));
                    if (cmd_ready) void'(exp_cmd.pop_front());
                end
            end
            if (wr_valid) begin
                if (exp_wr.size() == 0) begin
                    report_unexpected("wr_valid");
                end else begin
                    checkOutput("wr_data", 32'(wr_data), 32'(exp_wr[0]));
                    if (wr_ready) void'(exp_wr.pop_front());
                end
            end
            if (err) begin
                if (exp_err.size() == 0) begin
                    report_unexpected("err");
                end else begin
                    checkOutput("err_code", 32'(err_code), 32'(exp_err.pop_front()));
                    checkOutput("busy_at_err", 32'(busy), 32'd0);
                end
            end
        end
    end

    // Presents one byte: strobe high for 'hold' clocks, then low for 'gap'.
    task automatic applyStimulus(input logic [7:0] b, input int hold, input int gap);
        rx_data   = b;
        rx_strobe = 1'b1;
        repeat (hold) begin @(posedge clk); #1; end
        rx_strobe = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_rand(input logic [7:0] b);
        applyStimulus(b, $urandom_range(1, 3), $urandom_range(4, 6));
    endtask

    function automatic logic [8:0] len_of(input logic [7:0] b);
        return (b == 8'h00) ? 9'd256 : {1'b0, b};
    endfunction

    task automatic send_header(input logic [7:0] op, input logic [23:0] addr,
                               input logic [7:0] len, input bit force_csum,
                               input logic [7:0] csum_val);
        logic [7:0] cs;
        cs = force_csum ? csum_val : (op ^ addr[23:16] ^ addr[15:8] ^ addr[7:0] ^ len);
        send_rand(SYNC);
        send_rand(op);
        send_rand(addr[23:16]);
        send_rand(addr[15:8]);
        send_rand(addr[7:0]);
        send_rand(len);
        send_rand(cs);
    endtask

    // Waits until every expected event has been seen and the block is idle.
    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (((exp_cmd.size() != 0) || (exp_err.size() != 0) || busy) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL %s: still waiting after %0d cycles (cmd %0d, err %0d, busy %0d), expected idle",
                     name, n, exp_cmd.size(), exp_err.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        checkOutput({name, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        checkOutput({name, "_cmd_op"},    32'(cmd_op),    32'd0);
        checkOutput({name, "_cmd_addr"},  32'(cmd_addr),  32'd0);
        checkOutput({name, "_cmd_len"},   32'(cmd_len),   32'd0);
        checkOutput({name, "_wr_data"},   32'(wr_data),   32'd0);
        checkOutput({name, "_wr_valid"},  32'(wr_valid),  32'd0);
        checkOutput({name, "_busy"},      32'(busy),      32'd0);
        checkOutput({name, "_err"},       32'(err),       32'd0);
        checkOutput({name, "_err_code"},  32'(err_code),  32'd0);
    endtask

    // Main sequence: directed frames first, then randomized frames.
    initial begin
        logic [7:0]  op, len, b0, b1, cs;
        logic [23:0] addr;
        int          kind, v;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        monitor_on = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // READ_ID with LEN 0 meaning 256 bytes.
        ready_mode = 1;
        exp_cmd.push_back('{op: 8'h01, addr: 24'h000000, len: 9'd256});
        send_header(8'h01, 24'h000000, 8'h00, 1'b0, 8'h00);
        wait_idle("t1", 100);
        checkOutput("t1_op_held",   32'(cmd_op),   32'h01);
        checkOutput("t1_addr_held", 32'(cmd_addr), 32'h000000);
        checkOutput("t1_len_held",  32'(cmd_len),  32'd256);

        // WRITE two bytes.
        exp_cmd.push_back('{op: 8'h03, addr: 24'h123456, len: 9'd2});
        exp_wr.push_back(8'hAA);
        exp_wr.push_back(8'h55);
        send_header(8'h03, 24'h123456, 8'h02, 1'b0, 8'h00);
        send_rand(8'hAA);
        send_rand(8'h55);
        wait_idle("t2", 200);
        checkOutput("t2_addr_held", 32'(cmd_addr), 32'h123456);
        checkOutput("t2_len_held",  32'(cmd_len),  32'd2);
        checkOutput("t2_wr_left",   32'(exp_wr.size()), 32'd0);

        // Bad checksum, then unknown opcode with a good checksum.
        exp_err.push_back(2'd0);
        send_header(8'h03, 24'h123456, 8'h02, 1'b1, 8'h00);
        wait_idle("t3a", 100);
        checkOutput("t3a_err_code", 32'(err_code), 32'd0);
        exp_err.push_back(2'd1);
        send_header(8'h07, 24'h123456, 8'h02, 1'b0, 8'h00);
        wait_idle("t3b", 100);
        checkOutput("t3b_err_code", 32'(err_code), 32'd1);

        // Silence inside the header.
        exp_err.push_back(2'd2);
        send_rand(SYNC);
        send_rand(8'h02);
        wait_idle("t4a", TIMEOUT + 50);
        checkOutput("t4a_err_code", 32'(err_code), 32'd2);
        checkOutput("t4a_busy",     32'(busy),     32'd0);

        // Silence inside the payload.
        exp_cmd.push_back('{op: 8'h03, addr: 24'hABCDEF, len: 9'd3});
        exp_wr.push_back(8'h11);
        exp_err.push_back(2'd2);
        send_header(8'h03, 24'hABCDEF, 8'h03, 1'b0, 8'h00);
        send_rand(8'h11);
        wait_idle("t4b", TIMEOUT + 100);
        checkOutput("t4b_err_code", 32'(err_code), 32'd2);
        checkOutput("t4b_wr_left",  32'(exp_wr.size()), 32'd0);

        // Payload overrun with the consumer stalled.
        ready_mode = 3;
        exp_cmd.push_back('{op: 8'h03, addr: 24'h000100, len: 9'd3});
        exp_wr.push_back(8'h21);
        exp_err.push_back(2'd3);
        send_header(8'h03, 24'h000100, 8'h03, 1'b0, 8'h00);
        send_rand(8'h21);
        send_rand(8'h22);
        wait_idle("t5", 100);
        checkOutput("t5_err_code", 32'(err_code), 32'd3);
        exp_wr.delete();

        // Reset in the middle of a header.
        ready_mode = 1;
        send_rand(SYNC);
        send_rand(8'h02);
        send_rand(8'h12);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        checkOutput("post_reset_err",  32'(err),  32'd0);

        // A SYNC strobe held high for many clocks counts once.
        exp_cmd.push_back('{op: 8'h02, addr: 24'h0A0B0C, len: 9'd16});
        applyStimulus(SYNC, 20, 5);
        send_rand(8'h02);
        send_rand(8'h0A);
        send_rand(8'h0B);
        send_rand(8'h0C);
        send_rand(8'h10);
        send_rand(8'h02 ^ 8'h0A ^ 8'h0B ^ 8'h0C ^ 8'h10);
        wait_idle("held_strobe", 100);

        // Bytes during a stalled non-WRITE command are ignored.
        ready_mode = 0;
        exp_cmd.push_back('{op: 8'h04, addr: 24'h010000, len: 9'd1});
        send_header(8'h04, 24'h010000, 8'h01, 1'b0, 8'h00);
        send_rand(SYNC);
        send_rand(8'h33);
        ready_mode = 1;
        wait_idle("issue_ignore", 100);

        // A WRITE byte arriving before the handshake is kept as payload.
        ready_mode = 0;
        exp_cmd.push_back('{op: 8'h03, addr: 24'h000040, len: 9'd1});
        exp_wr.push_back(8'h5A);
        send_header(8'h03, 24'h000040, 8'h01, 1'b0, 8'h00);
        send_rand(8'h5A);
        ready_mode = 1;
        wait_idle("issue_capture", 100);
        checkOutput("issue_capture_wr_left", 32'(exp_wr.size()), 32'd0);

        // Randomized frames with random handshake timing.
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 2);
            for (int k = 0; k < v; k++) begin
                b0 = 8'($urandom_range(0, 255));
                if (b0 == SYNC) b0 = 8'h00;
                send_rand(b0);
            end
            kind = $urandom_range(0, 9);
            addr = 24'($urandom);
            if (kind == 0) begin
                op  = 8'($urandom_range(0, 255));
                len = 8'($urandom_range(0, 255));
                cs  = (op ^ addr[23:16] ^ addr[15:8] ^ addr[7:0] ^ len) ^ 8'($urandom_range(1, 255));
                exp_err.push_back(2'd0);
                send_header(op, addr, len, 1'b1, cs);
            end else if (kind == 1) begin
                v   = $urandom_range(6, 256);
                op  = (v == 256) ? 8'h00 : 8'(v);
                len = 8'($urandom_range(0, 255));
                exp_err.push_back(2'd1);
                send_header(op, addr, len, 1'b0, 8'h00);
            end else begin
                op = (kind >= 6) ? 8'h03 : 8'($urandom_range(1, 5));
                if (op == 8'h03) len = (i == 5) ? 8'h00 : 8'($urandom_range(1, 6));
                else             len = 8'($urandom_range(0, 255));
                exp_cmd.push_back('{op: op, addr: addr, len: len_of(len)});
                if (op == 8'h03) begin
                    for (int k = 0; k < int'(len_of(len)); k++)
                        exp_wr.push_back(8'(((i * 37) + (k * 11) + 3) & 255));
                end
                send_header(op, addr, len, 1'b0, 8'h00);
                if (op == 8'h03) begin
                    for (int k = 0; k < int'(len_of(len)); k++)
                        send_rand(8'(((i * 37) + (k * 11) + 3) & 255));
                end
            end
            wait_idle($sformatf("rand%0d", i), 3000);
            checkOutput($sformatf("rand%0d_wr_left", i), 32'(exp_wr.size()), 32'd0);
            exp_wr.delete();
        end

        repeat (5) begin @(posedge clk); #1; end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
